// File: rtl/ibex_fpu_wb.sv
// FPU writeback: registers FP results, queues integer-destination results behind the integer pipe, holds fcsr.
// Latency: FP write 1 cycle, integer write 2 cycles (1 with IBEX_FPU_WB_BYPASS_EN); fpu_ready_o drops while the FIFO is full.
module ibex_fpu_wb #(
    parameter int unsigned INT_FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic        fpu_fp_we_i,
    input  logic        fpu_int_we_i,
    input  logic [4:0]  fpu_rd_addr_i,
    input  logic [31:0] fpu_wdata_i,
    input  logic [7:0]  fpu_status_i,
    input  logic        fpu_flags_en_i,
    input  logic        fpu_is_div_i,
    output logic        fp_rf_we_o,
    output logic [4:0]  fp_rf_waddr_o,
    output logic [31:0] fp_rf_wdata_o,
    input  logic        int_pipe_we_i,
    input  logic [4:0]  int_pipe_waddr_i,
    input  logic [31:0] int_pipe_wdata_i,
    output logic        int_rf_we_o,
    output logic [4:0]  int_rf_waddr_o,
    output logic [31:0] int_rf_wdata_o,
    input  logic        csr_we_i,
    input  logic [1:0]  csr_addr_i,
    input  logic [7:0]  csr_wdata_i,
    output logic [7:0]  csr_rdata_o,
    output logic [2:0]  frm_o,
    output logic [4:0]  fflags_o,
    output logic        int_pending_o
);

    localparam int unsigned PTR_W = $clog2(INT_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [4:0]       fifo_addr [INT_FIFO_DEPTH];
    logic [31:0]      fifo_data [INT_FIFO_DEPTH];

    logic       accept, int_acc, bypass, push, pop, fifo_empty;
    logic       csr_fflags_we, flag_upd;
    logic [4:0] dec_flags, fflags_base;

    assign fifo_empty    = (fifo_count == '0);
    assign fpu_ready_o   = (fifo_count < CNT_W'(INT_FIFO_DEPTH));
    assign int_pending_o = !fifo_empty;

    assign accept  = fpu_valid_i && fpu_ready_o;
    // A result with both enables set goes to the FP file only.
    assign int_acc = accept && fpu_int_we_i && !fpu_fp_we_i;

`ifdef IBEX_FPU_WB_BYPASS_EN
    assign bypass = int_acc && fifo_empty && !int_pipe_we_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = int_acc && !bypass;
    assign pop  = !int_pipe_we_i && !fifo_empty;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= fpu_rd_addr_i;
            fifo_data[wr_ptr] <= fpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fp_rf_we_o    <= 1'b0;
            fp_rf_waddr_o <= '0;
            fp_rf_wdata_o <= '0;
        end else begin
            fp_rf_we_o <= accept && fpu_fp_we_i;
            if (accept && fpu_fp_we_i) begin
                fp_rf_waddr_o <= fpu_rd_addr_i;
                fp_rf_wdata_o <= fpu_wdata_i;
            end
        end
    end

    // Integer pipe always wins; the FIFO drains only in its idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_rf_we_o    <= 1'b0;
            int_rf_waddr_o <= '0;
            int_rf_wdata_o <= '0;
        end else if (int_pipe_we_i) begin
            int_rf_we_o    <= 1'b1;
            int_rf_waddr_o <= int_pipe_waddr_i;
            int_rf_wdata_o <= int_pipe_wdata_i;
        end else if (pop) begin
            int_rf_we_o    <= 1'b1;
            int_rf_waddr_o <= fifo_addr[rd_ptr];
            int_rf_wdata_o <= fifo_data[rd_ptr];
        end else if (bypass) begin
            int_rf_we_o    <= 1'b1;
            int_rf_waddr_o <= fpu_rd_addr_i;
            int_rf_wdata_o <= fpu_wdata_i;
        end else begin
            int_rf_we_o <= 1'b0;
        end
    end

    assign flag_upd  = accept && fpu_flags_en_i;
    assign dec_flags = flag_upd ? {fpu_status_i[2], fpu_status_i[7] & fpu_is_div_i,
                                   fpu_status_i[4], fpu_status_i[3], fpu_status_i[5]} : 5'b0;

    logic unused_status;
    assign unused_status = ^{fpu_status_i[6], fpu_status_i[1:0]};

    assign csr_fflags_we = csr_we_i && ((csr_addr_i == 2'd0) || (csr_addr_i == 2'd2));
    // Flags raised by an op in the same cycle survive a software write.
    assign fflags_base   = csr_fflags_we ? csr_wdata_i[4:0] : fflags_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_o <= '0;
            frm_o    <= '0;
        end else begin
            fflags_o <= fflags_base | dec_flags;
            if (csr_we_i && csr_addr_i == 2'd1)      frm_o <= csr_wdata_i[2:0];
            else if (csr_we_i && csr_addr_i == 2'd2) frm_o <= csr_wdata_i[7:5];
        end
    end

    always_comb begin
        csr_rdata_o = 8'h00;
        case (csr_addr_i)
            2'd0:    csr_rdata_o = {3'b000, fflags_o};
            2'd1:    csr_rdata_o = {5'b00000, frm_o};
            2'd2:    csr_rdata_o = {frm_o, fflags_o};
            default: csr_rdata_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ibex_fpu_wb.sv
// Self-checking bench for ibex_fpu_wb: directed scenarios then randomized traffic against a queue-based model.
module tb_ibex_fpu_wb;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fpu_valid_i, fpu_ready_o, fpu_fp_we_i, fpu_int_we_i;
    logic [4:0]  fpu_rd_addr_i;
    logic [31:0] fpu_wdata_i;
    logic [7:0]  fpu_status_i;
    logic        fpu_flags_en_i, fpu_is_div_i;
    logic        fp_rf_we_o;
    logic [4:0]  fp_rf_waddr_o;
    logic [31:0] fp_rf_wdata_o;
    logic        int_pipe_we_i;
    logic [4:0]  int_pipe_waddr_i;
    logic [31:0] int_pipe_wdata_i;
    logic        int_rf_we_o;
    logic [4:0]  int_rf_waddr_o;
    logic [31:0] int_rf_wdata_o;
    logic        csr_we_i;
    logic [1:0]  csr_addr_i;
    logic [7:0]  csr_wdata_i, csr_rdata_o;
    logic [2:0]  frm_o;
    logic [4:0]  fflags_o;
    logic        int_pending_o;

    ibex_fpu_wb #(.INT_FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
        .fpu_fp_we_i(fpu_fp_we_i), .fpu_int_we_i(fpu_int_we_i),
        .fpu_rd_addr_i(fpu_rd_addr_i), .fpu_wdata_i(fpu_wdata_i),
        .fpu_status_i(fpu_status_i), .fpu_flags_en_i(fpu_flags_en_i), .fpu_is_div_i(fpu_is_div_i),
        .fp_rf_we_o(fp_rf_we_o), .fp_rf_waddr_o(fp_rf_waddr_o), .fp_rf_wdata_o(fp_rf_wdata_o),
        .int_pipe_we_i(int_pipe_we_i), .int_pipe_waddr_i(int_pipe_waddr_i), .int_pipe_wdata_i(int_pipe_wdata_i),
        .int_rf_we_o(int_rf_we_o), .int_rf_waddr_o(int_rf_waddr_o), .int_rf_wdata_o(int_rf_wdata_o),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .frm_o(frm_o), .fflags_o(fflags_o), .int_pending_o(int_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference state: pending integer writes as a queue of {addr,data}.
    logic [36:0] q[$];
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic        e_fp_we, e_int_we;
    logic [4:0]  e_fp_addr, e_int_addr;
    logic [31:0] e_fp_data, e_int_data;

    function automatic logic [7:0] model_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {3'b000, m_fflags};
            2'd1:    return {5'b00000, m_frm};
            2'd2:    return {m_frm, m_fflags};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_fflags = '0; m_frm = '0;
        e_fp_we = 0; e_int_we = 0;
        e_fp_addr = '0; e_int_addr = '0; e_fp_data = '0; e_int_data = '0;
    endtask

    task automatic idle_inputs();
        fpu_valid_i = 0; fpu_fp_we_i = 0; fpu_int_we_i = 0;
        fpu_rd_addr_i = '0; fpu_wdata_i = '0; fpu_status_i = '0;
        fpu_flags_en_i = 0; fpu_is_div_i = 0;
        int_pipe_we_i = 0; int_pipe_waddr_i = '0; int_pipe_wdata_i = '0;
        csr_we_i = 0; csr_addr_i = '0; csr_wdata_i = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        int  sz;
        logic acc, int_op, byp;
        logic [4:0] dec;
        #1;
        sz = q.size();
        chk("ready", fpu_ready_o, sz < DEPTH);
        chk("pending", int_pending_o, sz != 0);
        chk("fflags", fflags_o, m_fflags);
        chk("frm", frm_o, m_frm);
        chk("csr_rdata", csr_rdata_o, model_rdata(csr_addr_i));

        acc    = fpu_valid_i && (sz < DEPTH);
        int_op = acc && fpu_int_we_i && !fpu_fp_we_i;
`ifdef IBEX_FPU_WB_BYPASS_EN
        byp = int_op && sz == 0 && !int_pipe_we_i;
`else
        byp = 0;
`endif
        e_fp_we = acc && fpu_fp_we_i;
        if (e_fp_we) begin e_fp_addr = fpu_rd_addr_i; e_fp_data = fpu_wdata_i; end

        if (int_pipe_we_i) begin
            e_int_we = 1; e_int_addr = int_pipe_waddr_i; e_int_data = int_pipe_wdata_i;
        end else if (sz > 0) begin
            logic [36:0] h;
            h = q.pop_front();
            e_int_we = 1; e_int_addr = h[36:32]; e_int_data = h[31:0];
        end else if (byp) begin
            e_int_we = 1; e_int_addr = fpu_rd_addr_i; e_int_data = fpu_wdata_i;
        end else begin
            e_int_we = 0;
        end
        if (int_op && !byp) q.push_back({fpu_rd_addr_i, fpu_wdata_i});

        dec = (acc && fpu_flags_en_i) ?
              {fpu_status_i[2], fpu_status_i[7] & fpu_is_div_i, fpu_status_i[4], fpu_status_i[3], fpu_status_i[5]} : 5'b0;
        if (csr_we_i && (csr_addr_i == 0 || csr_addr_i == 2)) m_fflags = csr_wdata_i[4:0];
        m_fflags = m_fflags | dec;
        if (csr_we_i && csr_addr_i == 1) m_frm = csr_wdata_i[2:0];
        if (csr_we_i && csr_addr_i == 2) m_frm = csr_wdata_i[7:5];

        @(posedge clk_i); #1;
        chk("fp_we", fp_rf_we_o, e_fp_we);
        if (e_fp_we) begin
            chk("fp_waddr", fp_rf_waddr_o, e_fp_addr);
            chk("fp_wdata", fp_rf_wdata_o, e_fp_data);
        end
        chk("int_we", int_rf_we_o, e_int_we);
        if (e_int_we) begin
            chk("int_waddr", int_rf_waddr_o, e_int_addr);
            chk("int_wdata", int_rf_wdata_o, e_int_data);
        end
    endtask

    task automatic fpu_op(input logic fp, input logic iw, input logic [4:0] rd, input logic [31:0] d);
        fpu_valid_i = 1; fpu_fp_we_i = fp; fpu_int_we_i = iw; fpu_rd_addr_i = rd; fpu_wdata_i = d;
    endtask

    task automatic check_all_reset();
        chk("rst_fp_we", fp_rf_we_o, 0);
        chk("rst_fp_waddr", fp_rf_waddr_o, 0);
        chk("rst_fp_wdata", fp_rf_wdata_o, 0);
        chk("rst_int_we", int_rf_we_o, 0);
        chk("rst_int_waddr", int_rf_waddr_o, 0);
        chk("rst_int_wdata", int_rf_wdata_o, 0);
        chk("rst_fflags", fflags_o, 0);
        chk("rst_frm", frm_o, 0);
        chk("rst_ready", fpu_ready_o, 1);
        chk("rst_pending", int_pending_o, 0);
    endtask

    initial begin
        rst_ni = 0;
        idle_inputs();
        model_reset();
        #12;
        check_all_reset();
        rst_ni = 1;
        @(posedge clk_i); #1;

        // FP write
        fpu_op(1, 0, 5'd5, 32'h3F80_0000);
        cycle();
        chk("fpw_we", fp_rf_we_o, 1);
        chk("fpw_addr", fp_rf_waddr_o, 5);
        chk("fpw_data", fp_rf_wdata_o, 32'h3F80_0000);
        chk("fpw_int_idle", int_rf_we_o, 0);

        // Integer write latency
        fpu_op(0, 1, 5'd10, 32'h7);
        cycle();
        idle_inputs();
`ifdef IBEX_FPU_WB_BYPASS_EN
        chk("intw_lat1", int_rf_we_o, 1);
        chk("intw_addr", int_rf_waddr_o, 10);
        cycle();
`else
        chk("intw_lat1", int_rf_we_o, 0);
        cycle();
        chk("intw_lat2", int_rf_we_o, 1);
        chk("intw_addr", int_rf_waddr_o, 10);
        chk("intw_data", int_rf_wdata_o, 7);
`endif
        cycle();

        // Fill FIFO behind a busy integer pipe
        int_pipe_we_i = 1; int_pipe_waddr_i = 5'd20; int_pipe_wdata_i = 32'hAAAA;
        fpu_op(0, 1, 5'd1, 32'h11);
        cycle();
        fpu_op(0, 1, 5'd2, 32'h22);
        cycle();
        chk("full_ready", fpu_ready_o, 0);
        idle_inputs();
        cycle();
        chk("drain1_addr", int_rf_waddr_o, 1);
        cycle();
        chk("drain2_addr", int_rf_waddr_o, 2);
        chk("drain_ready", fpu_ready_o, 1);
        cycle();

        // Flag accumulation
        fpu_op(1, 0, 5'd3, 32'h0); fpu_flags_en_i = 1; fpu_is_div_i = 1; fpu_status_i = 8'h80;
        cycle();
        chk("flags_dz", fflags_o, 5'b01000);
        fpu_is_div_i = 0; fpu_status_i = 8'h20;
        cycle();
        chk("flags_nx", fflags_o, 5'b01001);

        // CSR clear with same-cycle NV
        csr_we_i = 1; csr_addr_i = 0; csr_wdata_i = 8'h00; fpu_status_i = 8'h04;
        cycle();
        chk("flags_csr_op", fflags_o, 5'b10000);

        // fcsr write
        idle_inputs();
        csr_we_i = 1; csr_addr_i = 2; csr_wdata_i = 8'hE3;
        cycle();
        csr_we_i = 0;
        #1;
        chk("fcsr_frm", frm_o, 3'b111);
        chk("fcsr_fflags", fflags_o, 5'b00011);
        chk("fcsr_rdata", csr_rdata_o, 8'hE3);
        csr_addr_i = 3;
        #1;
        chk("rsvd_rdata", csr_rdata_o, 8'h00);
        csr_addr_i = 2;

        // Reset with FIFO occupied
        int_pipe_we_i = 1;
        fpu_op(0, 1, 5'd7, 32'h77);
        cycle();
        fpu_op(1, 0, 5'd8, 32'h88);
        cycle();
        chk("pre_rst_pending", int_pending_o, 1);
        rst_ni = 0;
        #1;
        check_all_reset();
        idle_inputs();
        model_reset();
        #2 rst_ni = 1;
        @(posedge clk_i); #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] kind;
            fpu_valid_i    = ($urandom_range(0, 3) != 0);
            kind           = 4'($urandom_range(0, 15));
            fpu_fp_we_i    = (kind < 6) || (kind == 15);
            fpu_int_we_i   = (kind >= 6);
            fpu_rd_addr_i  = 5'($urandom);
            fpu_wdata_i    = $urandom;
            fpu_status_i   = 8'($urandom);
            fpu_flags_en_i = 1'($urandom);
            fpu_is_div_i   = 1'($urandom);
            int_pipe_we_i  = ($urandom_range(0, 9) < (i % 400 < 200 ? 7 : 2));
            int_pipe_waddr_i = 5'($urandom);
            int_pipe_wdata_i = $urandom;
            csr_we_i       = ($urandom_range(0, 9) == 0);
            csr_addr_i     = 2'($urandom);
            csr_wdata_i    = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_fpu_wb.md
# ibex_fpu_wb

Writeback stage directly downstream of the FPU datapath. Registers FPU results onto the FP register-file write port. Queues FPU integer-destination results (FCVT.W, FMV.X.W, compares) in a small FIFO so they can share the integer register-file write port with the integer pipeline. Also holds the architectural fcsr: sticky fflags accumulated from FPU status, plus frm.

## Interface
Parameters:
- INT_FIFO_DEPTH, 2: entries in the integer-writeback FIFO; legal values 2 or 4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- fpu_valid_i  in  1  FPU result valid this cycle
- fpu_ready_o  out  1  stage can accept; equals (fifo_count < INT_FIFO_DEPTH)
- fpu_fp_we_i  in  1  result targets FP register file
- fpu_int_we_i  in  1  result targets integer register file
- fpu_rd_addr_i  in  5  destination register
- fpu_wdata_i  in  32  result data
- fpu_status_i  in  8  DesignWare status byte of the producing unit
- fpu_flags_en_i  in  1  op updates fflags (arith/convert/compare; low for moves, sign-inject, class)
- fpu_is_div_i  in  1  op is divide; enables DZ decode
- fp_rf_we_o / fp_rf_waddr_o / fp_rf_wdata_o  out  1/5/32  registered FP register-file write
- int_pipe_we_i / int_pipe_waddr_i / int_pipe_wdata_i  in  1/5/32  integer-pipeline write request; always has priority
- int_rf_we_o / int_rf_waddr_o / int_rf_wdata_o  out  1/5/32  registered integer register-file write
- csr_we_i  in  1  CSR write strobe
- csr_addr_i  in  2  0 = fflags, 1 = frm, 2 = fcsr, 3 = reserved (write ignored, read 0)
- csr_wdata_i  in  8  write data, right-aligned
- csr_rdata_o  out  8  combinational read of the addressed register
- frm_o  out  3  current rounding mode to the FPU
- fflags_o  out  5  current {NV,DZ,OF,UF,NX}
- int_pending_o  out  1  FIFO non-empty

## Operation
- Accept: fpu_valid_i && fpu_ready_o. Non-accepted cycles have no side effects.
- FP write: on accept with fpu_fp_we_i, the FP port registers {1, addr, data}. Otherwise fp_rf_we_o = 0 next cycle.
- Integer write: on accept with fpu_int_we_i, push {addr, data} into the FIFO.
  - Both enables high is illegal; the FP write wins and nothing is pushed.
- Integer port arbitration, evaluated each cycle:
  1. If int_pipe_we_i, register the pipeline write.
  2. Else if the FIFO is non-empty, pop the head and register it.
  3. Else int_rf_we_o = 0 next cycle.
- FIFO: circular buffer with read/write pointers of clog2(INT_FIFO_DEPTH) bits; pointers wrap modulo depth.
  - count increments on push, decrements on pop, and is unchanged when both happen in the same cycle.
  - Order is preserved.
  - Push is refused when full, even if a pop occurs in the same cycle.
- Flag decode, when an accepted op has fpu_flags_en_i:
  - NV = status[2]
  - DZ = status[7] & fpu_is_div_i
  - OF = status[4]
  - UF = status[3]
  - NX = status[5]
- fflags update: fflags_next = (CSR write to fflags/fcsr ? csr_wdata_i[4:0] : fflags) | decoded_flags. The op's flags survive a same-cycle CSR write.
- frm update: written by csr addr 1 (wdata[2:0]) or addr 2 (wdata[7:5]).
- CSR read data:
  - addr 0: {3'b0, fflags}
  - addr 1: {5'b0, frm}
  - addr 2: {frm, fflags}

## Timing
- Reset values: all write enables, addresses and data are 0; fflags_o = 0; frm_o = 0 (RNE); fifo_count = 0; fpu_ready_o = 1; int_pending_o = 0.
- Reset asserted mid-operation discards all FIFO contents and any pending writes asynchronously.
- FP write latency: 1 cycle (accept in N → fp_rf_we_o in N+1).
- Integer write latency without contention: 2 cycles (push in N, pop in N+1, int_rf_we_o in N+2). Each cycle of int_pipe_we_i adds one cycle.
- fflags visible on fflags_o / csr_rdata_o the cycle after accept.
- Sustained int_pipe_we_i fills the FIFO; fpu_ready_o then drops and the FPU must hold its result until ready returns.

## Configuration
- IBEX_FPU_WB_BYPASS_EN defined: an accepted integer write is registered straight to the integer port, skipping the FIFO, when all of these hold:
  - fifo_count == 0
  - int_pipe_we_i == 0 in the same cycle

  Latency is then 1 cycle; otherwise the write is pushed as normal.
- Undefined: every FPU integer write goes through the FIFO (2-cycle minimum latency).

## Test plan
- Reset, then accept FP write rd=5 data=0x3F800000 → fp_rf_we_o=1, waddr=5, wdata=0x3F800000 next cycle; int port idle.
- Accept int write rd=10 data=0x7 with int_pipe_we_i low (no bypass) → int_rf_we_o=1, waddr=10, data=0x7 two cycles later. With IBEX_FPU_WB_BYPASS_EN → one cycle later.
- Hold int_pipe_we_i high; accept 2 int writes (rd 1, 2) → fpu_ready_o=0 after the 2nd. Release the pipe → rd1 then rd2 written in order, then fpu_ready_o=1.
- Accept div with status=0x80 and fpu_is_div_i=1, then mul with status=0x20 → fflags_o=5'b01000, then 5'b01001.
- Same cycle: csr_we_i addr 0 data 0, plus an accepted op with status=0x04 → fflags_o=5'b10000.
- Write fcsr 0xE3 → frm_o=3'b111, fflags_o=5'b00011, csr_rdata_o=0xE3 (addr 2). Assert rst_ni low mid-FIFO → all outputs return to reset values immediately.
